// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pkg
//  Description : Shared definitions for the immediate generator pipeline:
//                RV32/RV64 base opcodes, the 3-bit instruction format enum
//                and the decoded record {imm, fmt} passed from the decoder
//                to the pipeline buffer.
//  Config      : IMM_GEN_CSR_EN (consumed by imm_decode) enables decoding of
//                the SYSTEM/CSR opcode; the default build treats it as
//                illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

  // Widest immediate any configuration produces; narrower builds use the
  // low XLEN bits of the decoded record.
  localparam int IMM_MAX_W = 64;

  // Base-ISA major opcodes (instr[6:0]).
  localparam logic [6:0] c_opc_load      = 7'b0000011;
  localparam logic [6:0] c_opc_op_imm    = 7'b0010011;
  localparam logic [6:0] c_opc_auipc     = 7'b0010111;
  localparam logic [6:0] c_opc_op_imm_32 = 7'b0011011;
  localparam logic [6:0] c_opc_store     = 7'b0100011;
  localparam logic [6:0] c_opc_op        = 7'b0110011;
  localparam logic [6:0] c_opc_lui       = 7'b0110111;
  localparam logic [6:0] c_opc_op_32     = 7'b0111011;
  localparam logic [6:0] c_opc_branch    = 7'b1100011;
  localparam logic [6:0] c_opc_jalr      = 7'b1100111;
  localparam logic [6:0] c_opc_jal       = 7'b1101111;
  localparam logic [6:0] c_opc_system    = 7'b1110011;

  // Instruction format as reported on out_fmt.
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  // Decoded record produced by imm_decode.
  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    fmt_e                 fmt;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Purely combinational RV32/RV64 immediate decoder. Classifies
//                an instruction word by opcode and builds its immediate,
//                sign-extended to IMM_MAX_W bits (shift amounts and CSR
//                fields are zero-extended).
//  Parameters  : XLEN    - 32 or 64; selects shamt width and whether the
//                          OP-IMM-32 opcode is legal (any value other than
//                          64 behaves as 32).
//  Config      : IMM_GEN_CSR_EN - when defined, SYSTEM opcode decodes to
//                Z/I/R formats; otherwise it is illegal.
//  Ports       : instr_i [31:0]  raw instruction word
//                dec_o   dec_t   decoded {imm, fmt}
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  localparam bit c_rv64 = (XLEN == 64);

  logic [6:0]           w_opc;
  logic [2:0]           w_funct3;
  logic                 w_is_shift;
  logic [IMM_MAX_W-1:0] w_imm_i;
  logic [IMM_MAX_W-1:0] w_imm_s;
  logic [IMM_MAX_W-1:0] w_imm_b;
  logic [IMM_MAX_W-1:0] w_imm_u;
  logic [IMM_MAX_W-1:0] w_imm_j;
  logic [IMM_MAX_W-1:0] w_shamt;
  logic [IMM_MAX_W-1:0] w_shamt_w;

  assign w_opc      = instr_i[6:0];
  assign w_funct3   = instr_i[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  assign w_imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
  assign w_imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

  // Native shift amount is 6 bits wide on RV64, 5 bits on RV32; the upper
  // funct7 bits (e.g. instr[30] for SRAI) never leak into the immediate.
  generate
    if (c_rv64) begin : g_shamt64
      assign w_shamt = {58'd0, instr_i[25:20]};
    end else begin : g_shamt32
      assign w_shamt = {59'd0, instr_i[24:20]};
    end
  endgenerate

  // Word-sized shifts (OP-IMM-32) always use a 5-bit shamt.
  assign w_shamt_w = {59'd0, instr_i[24:20]};

  always_comb begin
    dec_o.imm = '0;
    dec_o.fmt = FMT_ILL;
    case (w_opc)
      c_opc_op_imm: begin
        dec_o.fmt = FMT_I;
        dec_o.imm = w_is_shift ? w_shamt : w_imm_i;
      end
      c_opc_load, c_opc_jalr: begin
        dec_o.fmt = FMT_I;
        dec_o.imm = w_imm_i;
      end
      c_opc_op_imm_32: begin
        if (c_rv64) begin
          dec_o.fmt = FMT_I;
          dec_o.imm = w_is_shift ? w_shamt_w : w_imm_i;
        end
      end
      c_opc_store: begin
        dec_o.fmt = FMT_S;
        dec_o.imm = w_imm_s;
      end
      c_opc_branch: begin
        dec_o.fmt = FMT_B;
        dec_o.imm = w_imm_b;
      end
      c_opc_lui, c_opc_auipc: begin
        dec_o.fmt = FMT_U;
        dec_o.imm = w_imm_u;
      end
      c_opc_jal: begin
        dec_o.fmt = FMT_J;
        dec_o.imm = w_imm_j;
      end
      c_opc_op, c_opc_op_32: begin
        dec_o.fmt = FMT_R;
      end
      c_opc_system: begin
`ifdef IMM_GEN_CSR_EN
        if (w_funct3[2]) begin
          // CSRR*I: 5-bit zimm lives in the rs1 field.
          dec_o.fmt = FMT_Z;
          dec_o.imm = {59'd0, instr_i[19:15]};
        end else if (w_funct3 != 3'b000) begin
          // CSRRW/S/C: CSR address, zero-extended.
          dec_o.fmt = FMT_I;
          dec_o.imm = {52'd0, instr_i[31:20]};
        end else begin
          dec_o.fmt = FMT_R;
        end
`else
        dec_o.fmt = FMT_ILL;
`endif
      end
      default: begin
        dec_o.fmt = FMT_ILL;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Valid/ready immediate generator. Each accepted instruction
//                is decoded by imm_decode and appears on out_* one cycle
//                later. A single skid entry absorbs one extra instruction
//                when the consumer stalls, so in_ready is a pure register
//                with no combinational path from out_ready. Illegal
//                instructions are counted in a saturating counter.
//  Parameters  : XLEN  - immediate width, 32 or 64
//                CNT_W - width of illegal_cnt
//  Config      : IMM_GEN_CSR_EN - enables CSR (SYSTEM) decoding in the
//                decoder; default build treats SYSTEM as illegal.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid / in_ready / in_instr[31:0]      input stream
//                out_valid / out_ready / out_imm[XLEN-1:0]
//                out_fmt[2:0] / out_illegal                output stream
//                illegal_cnt[CNT_W-1:0], cnt_clr           illegal counter
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  dec_t            w_dec;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_fire_in;
  logic            w_fire_out;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;
  fmt_e            out_fmt_q,   out_fmt_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
  fmt_e            skid_fmt_q,  skid_fmt_d;
  logic            in_ready_q,  in_ready_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i (in_instr),
    .dec_o   (w_dec)
  );

  assign w_dec_imm = w_dec.imm[XLEN-1:0];

  // On narrow builds the decoder's upper immediate bits are only sign
  // extension and are intentionally dropped.
  generate
    if (XLEN < IMM_MAX_W) begin : g_narrow
      logic w_unused_hi;
      assign w_unused_hi = ^w_dec.imm[IMM_MAX_W-1:XLEN];
    end
  endgenerate

  assign w_fire_in  = in_valid && in_ready_q;
  assign w_fire_out = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;

    if (!out_valid_q || w_fire_out) begin
      // Output register is free this cycle. The skid entry is older than
      // anything on the input; while it is occupied in_ready is low, so no
      // new instruction can compete with it.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        skid_valid_d = 1'b0;
      end else if (w_fire_in) begin
        out_valid_d = 1'b1;
        out_imm_d   = w_dec_imm;
        out_fmt_d   = w_dec.fmt;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_fire_in) begin
      // Output is stalled: park the new instruction in the skid entry.
      skid_valid_d = 1'b1;
      skid_imm_d   = w_dec_imm;
      skid_fmt_d   = w_dec.fmt;
    end

    in_ready_d = !skid_valid_d;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (w_fire_in && (w_dec.fmt == FMT_ILL) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_R;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_R;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = (out_fmt_q == FMT_ILL);
  assign illegal_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe. A 32-bit instance
//                (CNT_W=2) is driven through directed vectors, a stalled
//                stream, random traffic, counter saturation/clear and a
//                reset with both entries occupied; a scoreboard holds the
//                expected decode of every accepted instruction. A 64-bit
//                instance checks the RV64-only behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal, cnt_clr;
  logic [31:0] in_instr, out_imm;
  logic [2:0]  out_fmt;
  logic [1:0]  illegal_cnt;

  logic        in_valid64, in_ready64, out_valid64, out_illegal64;
  logic [31:0] in_instr64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [15:0] illegal_cnt64;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  exp_t sb_q[$];
  exp_t m_e;
  exp_t m_in;
  logic [1:0] m_cnt = 2'd0;

  logic [6:0] ops [0:14] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                             7'b0110011, 7'b0111011, 7'b0011011, 7'b1110011,
                             7'b1111111, 7'b0001111, 7'b0000000};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt), .cnt_clr(cnt_clr)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64),
    .out_valid(out_valid64), .out_ready(1'b1),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
    .illegal_cnt(illegal_cnt64), .cnt_clr(1'b0)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference decode, written with signed casts rather than bit replication.
  function automatic exp_t model(input logic [31:0] ins, input bit rv64);
    exp_t        e;
    logic [11:0] s;
    logic [12:0] b;
    logic [20:0] j;
    e.imm = 64'd0;
    e.fmt = 3'd7;
    s = {ins[31:25], ins[11:7]};
    b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'b0010011: begin
        e.fmt = 3'd1;
        if (ins[13:12] == 2'b01) e.imm = rv64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
        else                     e.imm = 64'($signed(ins[31:20]));
      end
      7'b0000011, 7'b1100111: begin e.fmt = 3'd1; e.imm = 64'($signed(ins[31:20])); end
      7'b0011011: if (rv64) begin
        e.fmt = 3'd1;
        e.imm = (ins[13:12] == 2'b01) ? 64'(ins[24:20]) : 64'($signed(ins[31:20]));
      end
      7'b0100011: begin e.fmt = 3'd2; e.imm = 64'($signed(s)); end
      7'b1100011: begin e.fmt = 3'd3; e.imm = 64'($signed(b)); end
      7'b0110111, 7'b0010111: begin e.fmt = 3'd4; e.imm = 64'($signed({ins[31:12], 12'h000})); end
      7'b1101111: begin e.fmt = 3'd5; e.imm = 64'($signed(j)); end
      7'b0110011, 7'b0111011: e.fmt = 3'd0;
`ifdef IMM_GEN_CSR_EN
      7'b1110011: begin
        if (ins[14])                  begin e.fmt = 3'd6; e.imm = 64'(ins[19:15]); end
        else if (ins[13:12] != 2'b00) begin e.fmt = 3'd1; e.imm = 64'(ins[31:20]); end
        else                          e.fmt = 3'd0;
      end
`endif
      default: e.fmt = 3'd7;
    endcase
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_cnt = 2'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          m_e = sb_q.pop_front();
          check_eq("sb_imm", 64'(out_imm), 64'(m_e.imm[31:0]));
          check_eq("sb_fmt", 64'(out_fmt), 64'(m_e.fmt));
          check_eq("sb_illegal", 64'(out_illegal), 64'(m_e.fmt == 3'd7));
          n_popped++;
        end
      end
      check_eq("cnt", 64'(illegal_cnt), 64'(m_cnt));
      m_in = model(in_instr, 1'b0);
      if (in_valid && in_ready) sb_q.push_back(m_in);
      if (cnt_clr) m_cnt = 2'd0;
      else if (in_valid && in_ready && (m_in.fmt == 3'd7) && (m_cnt != 2'b11)) m_cnt = m_cnt + 2'd1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one instruction until accepted (bounded); returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic rdy);
    in_valid  = 1'b1;
    in_instr  = ins;
    out_ready = rdy;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        cyc(1);
        in_valid = 1'b0;
        return;
      end
      cyc(1);
    end
    in_valid = 1'b0;
    check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_chk(input string tag, input logic [31:0] ins,
                          input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
    send(ins, 1'b1);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_imm"},   64'(out_imm),   64'(exp_imm));
    check_eq({tag, "_fmt"},   64'(out_fmt),   64'(exp_fmt));
  endtask

  task automatic send64(input string tag, input logic [31:0] ins,
                        input logic [63:0] exp_imm, input logic [2:0] exp_fmt);
    check_eq({tag, "_ready"}, 64'(in_ready64), 64'd1);
    in_valid64 = 1'b1;
    in_instr64 = ins;
    cyc(1);
    in_valid64 = 1'b0;
    check_eq({tag, "_valid"}, 64'(out_valid64), 64'd1);
    check_eq({tag, "_imm"},   out_imm64,        exp_imm);
    check_eq({tag, "_fmt"},   64'(out_fmt64),   64'(exp_fmt));
  endtask

  task automatic reset_release;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_eq("rst_inready_before_edge", 64'(in_ready), 64'd0);
    cyc(1);
    check_eq("rst_inready_after_edge", 64'(in_ready), 64'd1);
    check_eq("rst_outvalid_after_edge", 64'(out_valid), 64'd0);
  endtask

  logic [31:0] stream [0:5] = '{32'h00500113, 32'hFFF10193, 32'h00A12223,
                                32'hFFFFFFFF, 32'h800002B7, 32'h0080006F};

  initial begin
    int  idx;
    int  base;
    bit  saw_low;
    bit  fire;
    exp_t e;

    rst_n = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_valid64 = 1'b0; in_instr64 = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'd0);
    check_eq("rst_out_imm",   64'(out_imm),   64'd0);
    check_eq("rst_out_fmt",   64'(out_fmt),   64'd0);
    check_eq("rst_cnt",       64'(illegal_cnt), 64'd0);
    cyc(2);
    reset_release();

    // Directed decode vectors (32-bit).
    send_chk("addi",  32'h00200093, 32'h00000002, 3'd1);
    send_chk("beq",   32'hFE208F63, 32'hFFFFF7FE, 3'd3);
    send_chk("lui",   32'h123450B7, 32'h12345000, 3'd4);
    send_chk("slli",  32'h03F01093, 32'h0000001F, 3'd1);
    send_chk("srai",  32'h4050D093, 32'h00000005, 3'd1);
    send_chk("sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2);
    send_chk("jal",   32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5);
    send_chk("add",   32'h002081B3, 32'h00000000, 3'd0);
    send_chk("addiw32", 32'h0010009B, 32'h00000000, 3'd7);
`ifdef IMM_GEN_CSR_EN
    send_chk("csrrwi", 32'h3400D073, 32'h00000001, 3'd6);
`else
    send_chk("csrrwi", 32'h3400D073, 32'h00000000, 3'd7);
`endif
    cyc(2);

    // Stream of 6 with the consumer stalled on cycles 2-4.
    idx = 0; saw_low = 1'b0; base = n_popped;
    for (int c = 1; c <= 40 && idx < 6; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = 1'b1;
      in_instr  = stream[idx];
      if (!in_ready) saw_low = 1'b1;
      fire = in_ready;
      cyc(1);
      if (fire) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(4);
    check_eq("bp_all_accepted", 64'(idx), 64'd6);
    check_eq("bp_inready_dropped", 64'(saw_low), 64'd1);
    check_eq("bp_all_emerged", 64'(n_popped - base), 64'd6);
    check_eq("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Random traffic with random back-pressure and occasional clears.
    for (int i = 0; i < 150; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_instr      = $urandom();
      in_instr[6:0] = ops[$urandom_range(0, 14)];
      out_ready     = ($urandom_range(0, 3) != 0);
      cnt_clr       = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    cyc(4);
    check_eq("rnd_sb_empty", 64'(sb_q.size()), 64'd0);

    // Counter saturation with CNT_W=2, then clear beating an increment.
    cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
    check_eq("cnt_cleared", 64'(illegal_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      send(32'hFFFFFFFF, 1'b1);
      check_eq("ill_fmt", 64'(out_fmt), 64'd7);
      check_eq("ill_imm", 64'(out_imm), 64'd0);
      check_eq("ill_flag", 64'(out_illegal), 64'd1);
      check_eq("ill_cnt", 64'(illegal_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    cnt_clr = 1'b1;
    send(32'hFFFFFFFF, 1'b1);
    cnt_clr = 1'b0;
    check_eq("cnt_clr_priority", 64'(illegal_cnt), 64'd0);
    cyc(2);

    // RV64 instance.
    send64("rv64_lui",   32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
    send64("rv64_beq",   32'hFE208F63, 64'hFFFFFFFFFFFFF7FE, 3'd3);
    send64("rv64_slli",  32'h03F01093, 64'd63, 3'd1);
    e = model(32'h0010109B, 1'b1);
    send64("rv64_slliw", 32'h0010109B, e.imm, e.fmt);
    e = model(32'hFFF1009B, 1'b1);
    send64("rv64_addiw", 32'hFFF1009B, e.imm, e.fmt);

    // Reset with output and skid entries both occupied.
    cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
    send(32'hFFFFFFFF, 1'b0);
    send(32'hFFFFFFFF, 1'b0);
    check_eq("full_inready", 64'(in_ready), 64'd0);
    check_eq("full_cnt", 64'(illegal_cnt), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_cnt", 64'(illegal_cnt), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd0);
    check_eq("arst_out_fmt", 64'(out_fmt), 64'd0);
    out_ready = 1'b1;
    reset_release();
    send_chk("post_rst", 32'h00200093, 32'h00000002, 3'd1);
    cyc(3);
    check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
